caliptra_fpga_sync_step_ctrl: RTL
=================================

Name: caliptra_fpga_sync_step_ctrl

Overview:
Sits between the sync register block (step requests and cycle counts from software) and the clock gate that drives the emulated Caliptra core. It queues step requests and generates a registered, glitch-safe gate enable held high for exactly the requested number of aclk cycles. Back-to-back requests run with no gap. It also provides free-run and abort controls, remaining-cycle and total-cycle status, and a per-request completion pulse.

Parameters:
CNT_W, 32, width of the per-request cycle count and the remaining counter
TOTAL_W, 64, width of the total gated-cycle counter
QDEPTH, 2, request FIFO depth (power of two, >=2)

Ports:
aclk  in  1  clock; all state updates on posedge
rstn  in  1  asynchronous active-low reset
req_valid  in  1  step request valid
req_cycles  in  CNT_W  number of gated cycles requested (0 is legal)
req_ready  out  1  FIFO not full; request accepted on req_valid && req_ready at posedge
free_run  in  1  level; run the gated clock continuously while high
abort  in  1  single-cycle pulse; flush and stop
gate_en  out  1  registered enable to the ICG
busy  out  1  state != IDLE or FIFO non-empty
remaining  out  CNT_W  cycles left in the current request, including the current one
done_pulse  out  1  one cycle when a request completes (not on abort)
total_cycles  out  TOTAL_W  count of cycles with gate_en=1; wraps modulo 2^TOTAL_W
overflow_err  out  1  sticky; set on req_valid && !req_ready

Behaviour:
- Reset (async, rstn=0): gate_en=0, busy=0, remaining=0, done_pulse=0, total_cycles=0, overflow_err=0, FIFO empty, state IDLE. req_ready=1 one cycle after reset release.
- gate_en is a flop output. The downstream ICG latches it on the low phase, so enable changes never truncate a high phase.
- States: IDLE, RUN, FREE.
- IDLE, FIFO non-empty, free_run=0: pop the head.
  - head N>0: go to RUN, remaining=N, gate_en=1 next cycle.
  - head 0: stay IDLE, gate_en=0, done_pulse=1 for that cycle. One zero entry is popped per cycle.
- Latency: a request accepted at edge k into an empty FIFO in IDLE is popped at edge k+1. gate_en is high for cycles k+1..k+N, exactly N cycles.
- RUN: remaining decrements each cycle. At the edge where remaining==1:
  - done_pulse=1 for the next cycle.
  - If the FIFO head is non-zero and free_run=0: pop it, load remaining, stay RUN. gate_en stays high with no gap.
  - Otherwise: go to IDLE, gate_en=0. Any zero heads are then handled from IDLE.
- IDLE with free_run=1: go to FREE, gate_en=1, remaining=0.
- FREE: gate_en stays 1 while free_run=1. When free_run deasserts, return to IDLE and drop gate_en next cycle. Queued requests wait during FREE.
- free_run rising during RUN: has no effect until the current request ends. It is then checked before any pop.
- abort (any state, highest priority):
  - next cycle: FIFO flushed, state IDLE, gate_en=0, remaining=0, overflow_err cleared, no done_pulse.
  - a request presented in the same cycle as abort is dropped.
- total_cycles increments by 1 on every cycle where gate_en=1 and wraps silently.
- FIFO:
  - simultaneous push and pop when full is allowed, since pop frees the slot combinationally for req_ready.
  - the count never exceeds QDEPTH.
- Reset mid-RUN: gate_en drops asynchronously with rstn and all queued requests are lost.

Decomposition:
- Package caliptra_fpga_sync_step_pkg holds:
  - the state enum (IDLE/RUN/FREE)
  - default CNT_W/TOTAL_W constants
  - a step_req_t struct carrying the cycle count
- Natural sub-module: caliptra_fpga_sync_step_fifo, a synchronous FIFO of step_req_t with full/empty, a push-when-full-with-pop rule, a flush input, and async active-low reset.

Test Plan:
- Reset, then req 5 at edge k: gate_en high exactly 5 cycles (k+1..k+5), done_pulse at k+6, total_cycles=5, busy low at k+6.
- req 3 then req 2 back-to-back: gate_en continuous for 5 cycles, done_pulse twice (after cycle 3 and cycle 5), total_cycles=5.
- req 0: gate_en never high, done_pulse one cycle after pop, total_cycles=0.
- Fill FIFO (QDEPTH=2) while RUN with req 100, push a third request: req_ready=0, overflow_err=1; abort at cycle 10 gives gate_en=0 next cycle, FIFO empty, overflow_err=0, no done_pulse, total_cycles=10.
- free_run high for 7 cycles from IDLE with req 4 queued during it: 7 gated cycles, then 4 more after return to IDLE, total_cycles=11.
- Assert rstn low during RUN at remaining=3: gate_en=0 immediately, all outputs at reset values, no gated cycle after release without a new request.

Source files
------------

// File: rtl/caliptra_fpga_sync_step_pkg.sv
// Shared types for the FPGA sync step controller.
// State encoding, default widths and the queued step request.
package caliptra_fpga_sync_step_pkg;

  localparam int STEP_CNT_W   = 32;
  localparam int STEP_TOTAL_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FREE
  } step_state_e;

  typedef struct packed {
    logic [STEP_CNT_W-1:0] cycles;
  } step_req_t;

endpackage

// File: rtl/caliptra_fpga_sync_step_fifo.sv
// Small request FIFO for the step controller.
// A push into a full FIFO is taken when a pop frees the slot.
module caliptra_fpga_sync_step_fifo
  import caliptra_fpga_sync_step_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      aclk,
  input  logic      rstn,
  input  logic      flush,
  input  logic      push,
  input  step_req_t wdata,
  input  logic      pop,
  output step_req_t rdata,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;
  step_req_t     mem [DEPTH];

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr];

  // Pointer and occupancy tracking; flush empties in one cycle.
  always_ff @(posedge aclk or negedge rstn) begin
    if (!rstn) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      cnt <= cnt + {{AW{1'b0}}, do_push}
                 - {{AW{1'b0}}, do_pop};
    end
  end

  // Storage array.
  always_ff @(posedge aclk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push && !flush) begin
      mem[wptr] <= wdata;
    end
  end

endmodule

// File: rtl/caliptra_fpga_sync_step_ctrl.sv
// Step controller driving the emulated core clock gate.
// Gate enable is a flop so the ICG never sees a glitch.
module caliptra_fpga_sync_step_ctrl
  import caliptra_fpga_sync_step_pkg::*;
#(
  parameter int CNT_W   = STEP_CNT_W,
  parameter int TOTAL_W = STEP_TOTAL_W,
  parameter int QDEPTH  = 2
) (
  input  logic               aclk,
  input  logic               rstn,
  input  logic               req_valid,
  input  logic [CNT_W-1:0]   req_cycles,
  output logic               req_ready,
  input  logic               free_run,
  input  logic               abort,
  output logic               gate_en,
  output logic               busy,
  output logic [CNT_W-1:0]   remaining,
  output logic               done_pulse,
  output logic [TOTAL_W-1:0] total_cycles,
  output logic               overflow_err
);

  step_state_e      state_q;
  step_state_e      state_d;
  logic [CNT_W-1:0] rem_d;
  logic             gate_d;
  logic             done_d;
  logic             pop;
  logic             push;
  logic             full;
  logic             empty;
  logic             rdy_q;
  step_req_t        push_req;
  step_req_t        head_req;
  logic [CNT_W-1:0] head;

  assign push_req.cycles = STEP_CNT_W'(req_cycles);
  assign head            = CNT_W'(head_req.cycles);
  assign req_ready       = rdy_q && (!full || pop);
  assign push            = req_valid && req_ready && !abort;
  assign busy            = (state_q != ST_IDLE) || !empty;

  caliptra_fpga_sync_step_fifo #(
    .DEPTH (QDEPTH)
  ) u_fifo (
    .aclk  (aclk),
    .rstn  (rstn),
    .flush (abort),
    .push  (push),
    .wdata (push_req),
    .pop   (pop),
    .rdata (head_req),
    .full  (full),
    .empty (empty)
  );

  // Next state, gate and pop decisions; abort overrides everything.
  always_comb begin
    state_d = state_q;
    rem_d   = remaining;
    gate_d  = 1'b0;
    done_d  = 1'b0;
    pop     = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
      rem_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (free_run) begin
            state_d = ST_FREE;
            gate_d  = 1'b1;
            rem_d   = '0;
          end else if (!empty) begin
            pop = 1'b1;
            if (head != '0) begin
              state_d = ST_RUN;
              rem_d   = head;
              gate_d  = 1'b1;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (remaining == CNT_W'(1)) begin
            done_d = 1'b1;
            if (!empty && head != '0
                && !free_run) begin
              pop    = 1'b1;
              rem_d  = head;
              gate_d = 1'b1;
            end else begin
              state_d = ST_IDLE;
              rem_d   = '0;
            end
          end else begin
            rem_d  = remaining - CNT_W'(1);
            gate_d = 1'b1;
          end
        end
        ST_FREE: begin
          if (free_run) gate_d = 1'b1;
          else state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          rem_d   = '0;
        end
      endcase
    end
  end

  // Control registers and registered outputs.
  always_ff @(posedge aclk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      remaining  <= '0;
      gate_en    <= 1'b0;
      done_pulse <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      remaining  <= rem_d;
      gate_en    <= gate_d;
      done_pulse <= done_d;
      rdy_q      <= 1'b1;
    end
  end

  // Gated cycle counter and sticky overflow flag.
  always_ff @(posedge aclk or negedge rstn) begin
    if (!rstn) begin
      total_cycles <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (gate_en)
        total_cycles <= total_cycles + TOTAL_W'(1);
      if (abort)
        overflow_err <= 1'b0;
      else if (req_valid && !req_ready)
        overflow_err <= 1'b1;
    end
  end

endmodule
